// File: rtl/poly_mode_interpolator.sv
// poly_mode_interpolator: FIFO-buffered upsampler, run-time factor, zero-stuff or sample-hold fill.
module poly_mode_interpolator #(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_FACTOR   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int FACTOR_WIDTH = $clog2(MAX_FACTOR + 1),
  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_enable,
  input  logic [FACTOR_WIDTH-1:0] factor,
  input  logic                    hold_mode,
  input  logic                    overflow_clr,
  input  logic [DATA_WIDTH-1:0]   inter_in,
  input  logic                    inter_in_valid,
  output logic                    inter_in_ready,
  output logic [DATA_WIDTH-1:0]   inter_out,
  output logic                    inter_out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic [LEVEL_WIDTH-1:0]  fifo_level
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [FACTOR_WIDTH-1:0] F_ONE = FACTOR_WIDTH'(1);
  localparam logic [FACTOR_WIDTH-1:0] F_MAX = FACTOR_WIDTH'(MAX_FACTOR);
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FACTOR_WIDTH-1:0] l_eff, l_nx, phase, phase_nx, f_clamp;
  logic [DATA_WIDTH-1:0] sample_reg, sample_nx, out_nx;
  logic valid_nx, full, empty, adv, push, pop, drop, last;
  assign full = fifo_level == LEVEL_WIDTH'(FIFO_DEPTH);
  assign empty = fifo_level == '0;
  assign inter_in_ready = !full;
  assign adv = !inter_out_valid || out_ready;
  // A full FIFO drops the sample even if a pop frees a slot this cycle.
  assign push = inter_in_valid && !full;
  assign drop = inter_in_valid && full;
  assign f_clamp = factor == '0 ? F_ONE : factor > F_MAX ? F_MAX : factor;
  assign last = phase == l_eff - F_ONE;
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    l_nx = l_eff;
    sample_nx = sample_reg;
    out_nx = inter_out;
    valid_nx = inter_out_valid;
    pop = 1'b0;
    if (adv) begin
      if (state == EXPAND) begin
        out_nx = hold_mode ? sample_reg : '0;
        valid_nx = 1'b1;
        phase_nx = last ? '0 : phase + F_ONE;
        state_nx = last ? IDLE : EXPAND;
      end else if (!empty) begin
        pop = 1'b1;
        sample_nx = mem[rd_ptr];
        out_nx = mem[rd_ptr];
        valid_nx = 1'b1;
        l_nx = f_clamp;
        phase_nx = f_clamp > F_ONE ? F_ONE : '0;
        state_nx = f_clamp > F_ONE ? EXPAND : IDLE;
      end else begin
        valid_nx = 1'b0;
      end
    end
  end
  always_ff @(posedge clk)
    if (clk_enable && push) mem[wr_ptr] <= inter_in;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      l_eff <= F_ONE;
      sample_reg <= '0;
      inter_out <= '0;
      inter_out_valid <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
    end else if (clk_enable) begin
      state <= state_nx;
      phase <= phase_nx;
      l_eff <= l_nx;
      sample_reg <= sample_nx;
      inter_out <= out_nx;
      inter_out_valid <= valid_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) fifo_level <= push ? fifo_level + 1'b1 : fifo_level - 1'b1;
      overflow <= drop ? 1'b1 : overflow_clr ? 1'b0 : overflow;
    end
  end
endmodule

// File: tb/tb_poly_mode_interpolator.sv
// tb_poly_mode_interpolator: randomized scoreboard bench against a queue-based reference model.
module tb_poly_mode_interpolator;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst_n;
  logic clk_enable = 1'b0, hold_mode = 1'b0, overflow_clr = 1'b0;
  logic [3:0] factor = 4'd2;
  logic [15:0] inter_in = '0;
  logic inter_in_valid = 1'b0, out_ready = 1'b0;
  logic inter_in_ready, inter_out_valid, overflow;
  logic [15:0] inter_out;
  logic [4:0] fifo_level;
  int checks = 0, errors = 0;

  poly_mode_interpolator dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .factor(factor),
    .hold_mode(hold_mode), .overflow_clr(overflow_clr), .inter_in(inter_in),
    .inter_in_valid(inter_in_valid), .inter_in_ready(inter_in_ready),
    .inter_out(inter_out), .inter_out_valid(inter_out_valid), .out_ready(out_ready),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampf(int f);
    return f == 0 ? 1 : (f > 8 ? 8 : f);
  endfunction

  // Reference model: queue of accepted samples plus a count of outputs still owed for the current one.
  logic [15:0] q[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_cur = '0;
  int m_left = 0, m_pre;
  bit m_valid = 0, m_ovf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); exp_q.delete(); m_left = 0; m_valid = 0; m_ovf = 0;
    end else if (clk_enable) begin
      m_pre = q.size();
      if (!m_valid || out_ready) begin
        if (m_left > 0) begin
          m_left--; m_valid = 1; exp_q.push_back(hold_mode ? m_cur : 16'h0);
        end else if (m_pre > 0) begin
          m_cur = q.pop_front(); m_left = clampf(int'(factor)) - 1; m_valid = 1; exp_q.push_back(m_cur);
        end else m_valid = 0;
      end
      if (inter_in_valid) begin
        if (m_pre == DEPTH) m_ovf = 1;
        else q.push_back(inter_in);
      end
      if (overflow_clr && !(inter_in_valid && m_pre == DEPTH)) m_ovf = 0;
    end
  end

  // Monitor: state checks each cycle, data popped from the scoreboard on every handshake.
  logic [15:0] e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("valid", int'(inter_out_valid), int'(m_valid));
      chk("level", int'(fifo_level), q.size());
      chk("ready", int'(inter_in_ready), int'(q.size() < DEPTH));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (inter_out_valid && out_ready && clk_enable) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("data", int'(inter_out), int'(e));
        end
      end
    end
  end

  task automatic drive(bit v, logic [15:0] d, bit rdy, bit ce);
    inter_in_valid = v; inter_in = d; out_ready = rdy; clk_enable = ce;
    @(posedge clk); #2;
  endtask

  task automatic check_reset();
    chk("rst_out", int'(inter_out), 0);
    chk("rst_valid", int'(inter_out_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_ready", int'(inter_in_ready), 1);
  endtask

  initial begin
    logic [15:0] s1 [3];
    s1[0] = 16'd100; s1[1] = 16'hFF38; s1[2] = 16'd300;
    rst_n = 1'b0;
    #23;
    check_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    // zero-stuff by 2
    factor = 4'd2; hold_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, s1[i], 1, 1);
      drive(0, 0, 1, 1);
    end
    repeat (4) drive(0, 0, 1, 1);
    // sample-hold by 4 at the signed extremes
    factor = 4'd4; hold_mode = 1'b1;
    drive(1, 16'h7FFF, 1, 1);
    drive(1, 16'h8000, 1, 1);
    repeat (10) drive(0, 0, 1, 1);
    // backpressure and clock-enable freeze mid-expansion
    factor = 4'd3; hold_mode = 1'b0;
    drive(1, 16'h1234, 1, 1);
    drive(1, 16'h4321, 1, 1);
    drive(0, 0, 1, 1);
    repeat (5) drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    repeat (3) drive(0, 0, 1, 0);
    repeat (8) drive(0, 0, 1, 1);
    // overflow, then clear
    factor = 4'd8;
    for (int i = 0; i < 20; i++) drive(1, 16'($urandom), 1, 1);
    overflow_clr = 1'b1;
    drive(0, 0, 1, 1);
    overflow_clr = 1'b0;
    repeat (150) drive(0, 0, 1, 1);
    // factor change mid-sample, then factor 0 and 15
    factor = 4'd2;
    drive(1, 16'h0AAA, 1, 1);
    drive(1, 16'h0BBB, 1, 1);
    factor = 4'd5;
    repeat (10) drive(0, 0, 1, 1);
    factor = 4'd0;
    repeat (3) drive(1, 16'($urandom), 1, 1);
    repeat (4) drive(0, 0, 1, 1);
    factor = 4'd15;
    repeat (2) drive(1, 16'($urandom), 1, 1);
    repeat (20) drive(0, 0, 1, 1);
    // asynchronous reset mid-expansion with samples queued
    factor = 4'd4; hold_mode = 1'b1;
    repeat (4) drive(1, 16'($urandom), 1, 1);
    drive(0, 0, 1, 1);
    #1 rst_n = 1'b0;
    #1 check_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive(1, 16'h5A5A, 1, 1);
    repeat (8) drive(0, 0, 1, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) factor = 4'($urandom_range(0, 15));
      hold_mode = 1'($urandom);
      overflow_clr = $urandom_range(0, 39) == 0;
      drive($urandom_range(0, 99) < 35, 16'($urandom), $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) != 0);
    end
    overflow_clr = 1'b0;
    repeat (300) drive(0, 0, 1, 1);
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
